// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared types and constants for the 7-segment scan controller:
//               scan FSM state, segment "off" patterns, counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    // Scan FSM: dark anti-ghosting window, then the lit part of the slot
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Segment pattern that leaves every segment dark
    localparam logic [6:0] SEG_OFF_CC = 7'h00;  // active-high segments
    localparam logic [6:0] SEG_OFF_CA = 7'h7F;  // active-low segments

    // Bits needed to count 0..n-1 (never less than one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_7seg_decoder.sv
// ============================================================================
// Module      : hex_7seg_decoder
// Description : Combinational hex nibble to 7-segment decoder.
//               Bit order [0]=a ... [6]=g; polarity set by COMMON_ANODE_CATHODE
//               (0 = active-high segments, 1 = active-low segments).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_7seg_decoder #(
    parameter int COMMON_ANODE_CATHODE = 0
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    logic [6:0] w_seg_hi;

    // Active-high glyph lookup for 0-9, A, b, C, d, E, F
    always_comb begin
        w_seg_hi = 7'h00;
        case (i_nibble)
            4'h0: w_seg_hi = 7'h3F;
            4'h1: w_seg_hi = 7'h06;
            4'h2: w_seg_hi = 7'h5B;
            4'h3: w_seg_hi = 7'h4F;
            4'h4: w_seg_hi = 7'h66;
            4'h5: w_seg_hi = 7'h6D;
            4'h6: w_seg_hi = 7'h7D;
            4'h7: w_seg_hi = 7'h07;
            4'h8: w_seg_hi = 7'h7F;
            4'h9: w_seg_hi = 7'h6F;
            4'hA: w_seg_hi = 7'h77;
            4'hB: w_seg_hi = 7'h7C;
            4'hC: w_seg_hi = 7'h39;
            4'hD: w_seg_hi = 7'h5E;
            4'hE: w_seg_hi = 7'h79;
            default: w_seg_hi = 7'h71;
        endcase
    end

    assign o_seg = (COMMON_ANODE_CATHODE != 0) ? ~w_seg_hi : w_seg_hi;

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed multi-digit 7-segment scan controller with
//               double-buffered display value, per-slot blanking window and a
//               single shared hex decoder. All outputs are registered.
//               Optional macro SEG_SCAN_LZ_BLANK_EN enables leading-zero
//               suppression (digit 0 is always shown).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS             = 4,
    parameter int REFRESH_DIV          = 50000,
    parameter int BLANK_CYCLES         = 8,
    parameter int COMMON_ANODE_CATHODE = 0,
    parameter int DIG_ACTIVE_LOW       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic                  i_load,
    output logic [6:0]            o_HEX,
    output logic [N_DIGITS-1:0]   o_dig_en,
    output logic                  o_pending
);

    localparam int PRESC_W = cnt_width(REFRESH_DIV);
    localparam int IDX_W   = cnt_width(N_DIGITS);

    localparam logic [6:0]          C_SEG_OFF    = (COMMON_ANODE_CATHODE != 0) ? SEG_OFF_CA : SEG_OFF_CC;
    localparam logic [N_DIGITS-1:0] C_DIG_OFF    = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [PRESC_W-1:0]  C_PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0]  C_BLANK_END  = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    C_IDX_LAST   = IDX_W'(N_DIGITS - 1);

    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    scan_state_t           r_state;
    scan_state_t           w_state_nxt;
    logic [4*N_DIGITS-1:0] r_shadow;
    logic [4*N_DIGITS-1:0] r_disp;
    logic                  r_pending;

    logic [PRESC_W-1:0]    w_presc_nxt;
    logic                  w_tick;
    logic                  w_frame;
    logic [3:0]            w_nibble;
    logic [6:0]            w_dec_seg;
    logic                  w_lz;
    logic [N_DIGITS-1:0]   w_onehot;
    logic [6:0]            w_hex_nxt;
    logic [N_DIGITS-1:0]   w_dig_nxt;

    assign w_tick      = (r_presc == C_PRESC_LAST);
    assign w_frame     = w_tick && (r_idx == C_IDX_LAST);
    assign w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;

    // Slot prescaler and digit index; index wraps at N_DIGITS-1 for any N
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_presc_nxt;
            if (w_tick) begin
                r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Double buffer: loads land in the shadow and are promoted only on a frame
    // boundary; a load on the boundary itself goes straight to the display
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else if (w_frame) begin
            r_pending <= 1'b0;
            if (i_load) begin
                r_disp   <= i_value;
                r_shadow <= i_value;
            end else if (r_pending) begin
                r_disp <= r_shadow;
            end
        end else if (i_load) begin
            r_shadow  <= i_value;
            r_pending <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: each slot opens dark, lights once the blanking window ends
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            w_state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end else if ((r_state == BLANK) && (w_presc_nxt >= C_BLANK_END)) begin
            w_state_nxt = SHOW;
        end
    end

    // Current-digit nibble mux and one-hot digit select
    always_comb begin
        w_nibble = 4'h0;
        w_onehot = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble    = r_disp[4*k +: 4];
                w_onehot[k] = 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Digit is suppressed when it and every more-significant nibble are zero
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        w_lz       = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (r_disp[4*k +: 4] == 4'h0);
            if (r_idx == IDX_W'(k)) begin
                w_lz = zero_above;
            end
        end
    end
`else
    assign w_lz = 1'b0;
`endif

    hex_7seg_decoder #(
        .COMMON_ANODE_CATHODE (COMMON_ANODE_CATHODE)
    ) u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    // FSM outputs: dark during BLANK, current digit lit during SHOW
    always_comb begin
        w_hex_nxt = C_SEG_OFF;
        w_dig_nxt = C_DIG_OFF;
        if (r_state == SHOW) begin
            w_hex_nxt = w_lz ? C_SEG_OFF : w_dec_seg;
            w_dig_nxt = (DIG_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
        end
    end

    // Output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_HEX    <= C_SEG_OFF;
            o_dig_en <= C_DIG_OFF;
        end else begin
            o_HEX    <= w_hex_nxt;
            o_dig_en <= w_dig_nxt;
        end
    end

    assign o_pending = r_pending;

endmodule

`default_nettype wire
